// File: rtl/mem_arbiter.sv
// Shares one memory bus between the CPU and the debug unit: debug has priority,
// and a streak limit keeps either side from being locked out. All state moves on the falling clock edge.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int LATENCY   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_rw,
    input  logic [ADDR_W-1:0] dbg_adr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_RW,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);
    localparam logic [3:0] MB4  = 4'(MAX_BURST);

    state_t            state_reg, state_next;
    logic [3:0]        count_reg, count_next;
    logic [3:0]        streak_reg, streak_next;
    logic              owner_reg, owner_next;
    logic [ADDR_W-1:0] adr_reg, adr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              rw_reg, rw_next;
    logic              win;
    logic [1:0]        ack_vec;

    always_ff @(negedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg  <= IDLE;
            count_reg  <= 4'd0;
            streak_reg <= 4'd0;
            owner_reg  <= 1'b0;
            adr_reg    <= '0;
            wdata_reg  <= '0;
            rw_reg     <= 1'b1;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            streak_reg <= streak_next;
            owner_reg  <= owner_next;
            adr_reg    <= adr_next;
            wdata_reg  <= wdata_next;
            rw_reg     <= rw_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        streak_next = streak_reg;
        owner_next  = owner_reg;
        adr_next    = adr_reg;
        wdata_next  = wdata_reg;
        rw_next     = rw_reg;
        win         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // Contention: debug wins unless it has used up its streak.
                    if (cpu_req && dbg_req)
                        win = !(owner_reg && (streak_reg == MB4));
                    else
                        win = dbg_req;
                    adr_next   = win ? dbg_adr : cpu_adr;
                    rw_next    = win ? dbg_rw : cpu_rw;
                    wdata_next = win ? dbg_wdata : cpu_wdata;
                    if (win != owner_reg)
                        streak_next = 4'd1;
                    else if (streak_reg < MB4)
                        streak_next = streak_reg + 4'd1;
                    owner_next = win;
                    count_next = LAT4;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-port read-data holding register and completion pulse; index 0 = CPU, 1 = debug.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;
            logic              capture;

            assign capture = (state_reg == ACCESS) && (count_reg == 4'd1) && rw_reg
                             && (owner_reg == 1'(gi));

            always_ff @(negedge clk or negedge n_reset) begin
                if (!n_reset)
                    rdata_reg <= '0;
                else if (capture)
                    rdata_reg <= mem_rdata;
            end

            assign ack_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign cpu_rdata = g_port[0].rdata_reg;
    assign dbg_rdata = g_port[1].rdata_reg;
    assign cpu_ack   = ack_vec[0];
    assign dbg_ack   = ack_vec[1];

    // Bus strobes decode straight from state so reset drops them without waiting for a clock.
    assign mem_en    = (state_reg == ACCESS);
    assign mem_RW    = (state_reg == ACCESS) ? rw_reg : 1'b1;
    assign mem_adr   = adr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign owner     = owner_reg;

endmodule
